// File: rtl/systolic_pe_if.sv
// Systolic PE port bundle: operand flow, accumulate
// control and the daisy-chained psum drain path.
interface systolic_pe_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
);
  logic              in_valid;
  logic              acc_clr;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              out_valid;
  logic              drain_start;
  logic [ACC_W-1:0]  psum_in;
  logic              psum_valid_in;
  logic [ACC_W-1:0]  psum_out;
  logic              psum_valid_out;
  logic              busy;
  logic              ovf;

  modport master (
    output in_valid, acc_clr, a_in, b_in,
    output drain_start, psum_in, psum_valid_in,
    input  a_out, b_out, out_valid,
    input  psum_out, psum_valid_out, busy, ovf
  );

  modport slave (
    input  in_valid, acc_clr, a_in, b_in,
    input  drain_start, psum_in, psum_valid_in,
    output a_out, b_out, out_valid,
    output psum_out, psum_valid_out, busy, ovf
  );
endinterface

// File: rtl/systolic_pe.sv
// Output-stationary systolic MAC cell with operand
// forwarding and a chained psum drain.
module systolic_pe #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int SIGNED    = 1,
  parameter int SAT       = 1,
  parameter int CHAIN_POS = 0
) (
  input  logic          clk,
  input  logic          rst_b,
  systolic_pe_if.slave  pe
);

  localparam int CNT_W =
    (CHAIN_POS > 0) ? $clog2(CHAIN_POS + 1) : 1;

  localparam logic [ACC_W-1:0] SMAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN =
    {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = '1;

  typedef enum logic {
    ACC   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_out_q, a_out_d;
  logic [DATA_W-1:0] b_out_q, b_out_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  psum_q, psum_d;
  logic              psum_valid_q, psum_valid_d;
  logic              ovf_q, ovf_d;

  logic [2*DATA_W-1:0] ea, eb, prod;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W:0]      sum;
  logic                sum_ovf;
  logic [ACC_W-1:0]    sat_val;
  logic [ACC_W-1:0]    acc_nx;
  logic                mac;
  logic                ov_hit;

  // Operand extension, product and widened sum with overflow detect
  always_comb begin
    ea = '0;
    eb = '0;
    ea[DATA_W-1:0] = pe.a_in;
    eb[DATA_W-1:0] = pe.b_in;
    for (int i = DATA_W; i < 2*DATA_W; i++) begin
      ea[i] = (SIGNED != 0) && pe.a_in[DATA_W-1];
      eb[i] = (SIGNED != 0) && pe.b_in[DATA_W-1];
    end
    prod = ea * eb;
    prod_ext = '0;
    prod_ext[2*DATA_W-1:0] = prod;
    for (int i = 2*DATA_W; i < ACC_W; i++) begin
      prod_ext[i] = (SIGNED != 0) && prod[2*DATA_W-1];
    end
    sum = {(SIGNED != 0) && acc_q[ACC_W-1], acc_q}
        + {(SIGNED != 0) && prod_ext[ACC_W-1], prod_ext};
    if (SIGNED != 0) begin
      sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
      sat_val = sum[ACC_W] ? SMIN : SMAX;
    end else begin
      sum_ovf = sum[ACC_W];
      sat_val = UMAX;
    end
  end

  // Next-state: accumulate, drain load / pass-through, forwarding
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    a_out_d      = a_out_q;
    b_out_d      = b_out_q;
    out_valid_d  = pe.in_valid;
    psum_d       = psum_q;
    psum_valid_d = 1'b0;
    ovf_d        = ovf_q;
    mac          = (state_q == ACC) && pe.in_valid;
    acc_nx       = acc_q;
    ov_hit       = 1'b0;

    if (pe.in_valid) begin
      a_out_d = pe.a_in;
      b_out_d = pe.b_in;
    end

    if (mac) begin
      if (pe.acc_clr) begin
        acc_nx = prod_ext;
      end else begin
        ov_hit = sum_ovf;
        acc_nx = (sum_ovf && (SAT != 0))
               ? sat_val : sum[ACC_W-1:0];
      end
    end

    unique case (state_q)
      ACC: begin
        acc_d = acc_nx;
        if ((mac && pe.acc_clr) || pe.drain_start) begin
          ovf_d = 1'b0;
        end
        if (ov_hit) begin
          ovf_d = 1'b1;
        end
        if (pe.drain_start) begin
          psum_d       = acc_nx;
          psum_valid_d = 1'b1;
          acc_d        = '0;
          if (CHAIN_POS > 0) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(CHAIN_POS);
          end
        end
      end
      DRAIN: begin
        if (pe.psum_valid_in) begin
          psum_d       = pe.psum_in;
          psum_valid_d = 1'b1;
          cnt_d        = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ACC;
          end
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= ACC;
      acc_q        <= '0;
      cnt_q        <= '0;
      a_out_q      <= '0;
      b_out_q      <= '0;
      out_valid_q  <= 1'b0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      a_out_q      <= a_out_d;
      b_out_q      <= b_out_d;
      out_valid_q  <= out_valid_d;
      psum_q       <= psum_d;
      psum_valid_q <= psum_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign pe.a_out          = a_out_q;
  assign pe.b_out          = b_out_q;
  assign pe.out_valid      = out_valid_q;
  assign pe.psum_out       = psum_q;
  assign pe.psum_valid_out = psum_valid_q;
  assign pe.busy           = (state_q == DRAIN);
  assign pe.ovf            = ovf_q;

endmodule

// File: doc/systolic_pe.md
SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator/psum width, ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter SIGNED, default 1, 1 = two's-complement operands, 0 = unsigned.
REQ-004 SHALL have parameter SAT, default 1, 1 = saturating accumulate, 0 = wrapping.
REQ-005 SHALL have parameter CHAIN_POS, default 0, number of upstream PEs whose psums pass through during drain.
REQ-006 SHALL use reset rst_b, asynchronous, active-low, and clock clk.
REQ-007 Ports: clk in 1 clock; rst_b in 1 reset; in_valid in 1 operand strobe; acc_clr in 1 start new dot product.
REQ-008 Ports: a_in in DATA_W west operand; b_in in DATA_W north operand; a_out out DATA_W east operand; b_out out DATA_W south operand; out_valid out 1 forwarded strobe.
REQ-009 Ports: drain_start in 1 begin result shift-out; psum_in in ACC_W upstream psum; psum_valid_in in 1 upstream psum strobe.
REQ-010 Ports: psum_out out ACC_W psum to downstream; psum_valid_out out 1 psum strobe; busy out 1 high while draining; ovf out 1 sticky overflow.

Function
REQ-011 SHALL implement a two-state FSM, ACC and DRAIN; busy SHALL be 1 exactly in DRAIN.
REQ-012 Product SHALL be a_in*b_in at 2*DATA_W bits: signed if SIGNED=1, else unsigned; sign- or zero-extended to ACC_W.
REQ-013 In ACC with in_valid=1: acc <= ext(product) if acc_clr=1, else acc <= acc + ext(product); result visible next cycle.
REQ-014 acc_clr with in_valid=0 SHALL have no effect.
REQ-015 SHALL register a_out<=a_in, b_out<=b_in, out_valid<=1 on every cycle with in_valid=1, in either state; 1-cycle latency.
REQ-016 SHALL set out_valid<=0 when in_valid=0; a_out/b_out hold.
REQ-017 SAT=1: on signed overflow, clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1); unsigned (SIGNED=0): clamp to 2^ACC_W-1.
REQ-018 SAT=0: the sum wraps modulo 2^ACC_W.
REQ-019 Under either SAT setting, an overflowing accumulate SHALL set ovf.
REQ-020 ovf SHALL be cleared by an accepted acc_clr (in_valid=1) or by drain_start, unless the same cycle overflows.
REQ-021 drain_start in ACC: psum_out <= acc_next (value including any same-cycle in_valid product); psum_valid_out <= 1; acc <= 0.
REQ-022 drain_start in ACC with CHAIN_POS=0: FSM SHALL stay in ACC.
REQ-023 drain_start in ACC with CHAIN_POS>0: FSM SHALL go to DRAIN and load the beat counter with CHAIN_POS.
REQ-024 In DRAIN: psum_out <= psum_in and psum_valid_out <= psum_valid_in each cycle.
REQ-025 In DRAIN: each psum_valid_in=1 SHALL decrement the beat counter; the beat taking it to 0 SHALL return the FSM to ACC next cycle.
REQ-026 In DRAIN, in_valid operands SHALL be forwarded per REQ-015, but the product is discarded and acc is unchanged.
REQ-027 drain_start in DRAIN SHALL be ignored.
REQ-028 Outside a drain load or pass-through beat, psum_valid_out SHALL be 0 and psum_out SHALL hold.
REQ-029 Counter width SHALL be clog2(CHAIN_POS+1), minimum 1.

Reset
REQ-030 rst_b low SHALL asynchronously force state ACC, acc=0, counter=0, a_out=0, b_out=0, psum_out=0, out_valid=0, psum_valid_out=0, ovf=0.
REQ-031 Reset mid-drain SHALL abort the drain; after release, the first cycle SHALL be in ACC with no psum_valid_out.

Verification
REQ-032 Defaults: in_valid with acc_clr=1 (3,4), then (-2,5), (7,1) -> acc=12-10+7=9; then drain_start -> psum_out=9, psum_valid_out=1 one cycle later; acc=0.
REQ-033 SIGNED=1, SAT=1, ACC_W=16, DATA_W=8: repeat 127*127 x3 -> acc=32767, ovf=1; acc_clr with (1,1) -> acc=1, ovf=0.
REQ-034 SAT=0, same sizes: 127*127 x3 -> acc=48387-65536=-17149, ovf=1.
REQ-035 CHAIN_POS=2: drain_start with acc=5, then psum_in=11 and 22 with psum_valid_in on non-consecutive cycles -> psum_out sequence 5,11,22; busy high until after the 2nd beat; in_valid during DRAIN leaves acc=0 but out_valid toggles.
REQ-036 drain_start and in_valid (2,3) in the same cycle with acc=10 -> psum_out=16, acc=0.
REQ-037 Assert rst_b low during DRAIN with CHAIN_POS=2 -> immediately busy=0, psum_valid_out=0, all outputs 0; the next drain_start behaves normally.
